// File: rtl/decay_pkg.sv
// Shared types, default widths and helpers for the muon decay timer.
//   state_t  : measurement FSM states
//   TW_DEF   : default time/interval width
//   GW_DEF   : default min_gap width
//   CW_DEF   : default event counter width
//   sat_inc  : increment that holds at the all-ones value of a w-bit field
package decay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DEAD  = 2'd2
  } state_t;

  localparam int TW_DEF = 16;
  localparam int GW_DEF = 12;
  localparam int CW_DEF = 32;

  // Value is carried in 64 bits so one helper serves every counter width
  // up to 64; the caller truncates the result back to its own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] top;
    top = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (v >= top) ? top : v + 64'd1;
  endfunction

endpackage

// File: rtl/decay_timer_hit_sync_edge.sv
// Three-flop synchroniser for an asynchronous hit line plus a one-cycle
// rising-edge pulse. A hit held high yields a single pulse.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears all three flops
//   hit  : asynchronous discriminator output
//   rise : one-cycle pulse, s2 & ~s3
module hit_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic hit,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= hit;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/decay_timer.sv
// Muon lifetime timer: measures clock cycles between a first hit (stop)
// and a second hit (decay electron) inside a programmable window, offers
// each interval on a valid/ready port and keeps saturating rate counters.
//   clk, rst            : clock, synchronous active-high reset
//   hit                 : asynchronous discriminator line
//   enable              : measurement enable
//   window, min_gap     : accepted interval range [min_gap, window]
//   dead_time           : hold-off after an event closes (min one cycle)
//   dt, dt_valid, dt_ready : result port
//   busy                : FSM not in IDLE
//   n_first, n_decay, n_timeout, n_lost : saturating event counters
module decay_timer
  import decay_pkg::*;
#(
  parameter int TW = TW_DEF,
  parameter int GW = GW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hit,
  input  logic          enable,
  input  logic [TW-1:0] window,
  input  logic [GW-1:0] min_gap,
  input  logic [TW-1:0] dead_time,
  output logic [TW-1:0] dt,
  output logic          dt_valid,
  input  logic          dt_ready,
  output logic          busy,
  output logic [CW-1:0] n_first,
  output logic [CW-1:0] n_decay,
  output logic [CW-1:0] n_timeout,
  output logic [CW-1:0] n_lost
);

  logic          rise;
  state_t        state, state_n;
  logic [TW-1:0] t, t_n;
  logic [TW-1:0] d, d_n;
  logic          inc_first, capture, timeout;
  logic          gap_ok;
  logic [TW:0]   d_plus1, dead_eff;

  hit_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .hit  (hit),
    .rise (rise)
  );

  assign gap_ok   = 32'(t) >= 32'(min_gap);
  assign d_plus1  = {1'b0, d} + (TW+1)'(1);
  // dead_time of 0 behaves like 1: DEAD always lasts at least one cycle.
  assign dead_eff = (dead_time == '0) ? (TW+1)'(1) : {1'b0, dead_time};

  always_comb begin
    state_n   = state;
    t_n       = t;
    d_n       = d;
    inc_first = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise && enable) begin
          state_n   = ARMED;
          t_n       = TW'(1);
          inc_first = 1'b1;
        end
      end
      ARMED: begin
        // Capture is tested before timeout so an edge at t == window counts.
        if (!enable) begin
          state_n = IDLE;
        end else if (rise && gap_ok) begin
          capture = 1'b1;
          state_n = DEAD;
          d_n     = '0;
        end else if (t >= window) begin
          timeout = 1'b1;
          state_n = DEAD;
          d_n     = '0;
        end else if (t != '1) begin
          t_n = t + TW'(1);
        end
      end
      DEAD: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (d_plus1 < dead_eff) begin
          d_n = d + TW'(1);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      t         <= '0;
      d         <= '0;
      dt        <= '0;
      dt_valid  <= 1'b0;
      busy      <= 1'b0;
      n_first   <= '0;
      n_decay   <= '0;
      n_timeout <= '0;
      n_lost    <= '0;
    end else begin
      state <= state_n;
      t     <= t_n;
      d     <= d_n;
      // busy is computed from the next state so it matches state exactly.
      busy  <= (state_n != IDLE);

      if (inc_first) n_first   <= CW'(sat_inc(64'(n_first), CW));
      if (timeout)   n_timeout <= CW'(sat_inc(64'(n_timeout), CW));

      if (capture) begin
        n_decay <= CW'(sat_inc(64'(n_decay), CW));
        // A slot is free if empty or being drained this very cycle.
        if (!dt_valid || dt_ready) begin
          dt       <= t;
          dt_valid <= 1'b1;
        end else begin
          n_lost <= CW'(sat_inc(64'(n_lost), CW));
        end
      end else if (dt_valid && dt_ready) begin
        dt_valid <= 1'b0;
      end
    end
  end

endmodule
